// File: rtl/regfile_pkg.sv
// Shared widths, types and helpers for the writeback register file.
package regfile_pkg;

    localparam int unsigned VLEN = 128;
    localparam int unsigned SLEN = 32;
    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [VLEN-1:0] vreg_t;
    typedef logic [SLEN-1:0] sreg_t;

    typedef enum logic {
        BANK_S = 1'b0,
        BANK_V = 1'b1
    } bank_e;

    // Scalar R0 is hardwired to zero: never written, never pending, never a hazard.
    function automatic logic is_s0(logic vf, reg_addr_t a);
        return (bank_e'(vf) == BANK_S) && (a == '0);
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// One register bank: a single write port and two combinational read ports with write bypass.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH   = VLEN,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  reg_addr_t        wa,
    input  logic [WIDTH-1:0] wd,
    input  reg_addr_t        ra1,
    input  reg_addr_t        ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] mem [NREG];
    logic             wr_ok;

    assign wr_ok = we && !(ZERO_R0 && (wa == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    // Same-cycle writes are forwarded so decode sees the committing value.
    always_comb begin
        rd1 = mem[ra1];
        rd2 = mem[ra2];
        if (wr_ok && (wa == ra1)) rd1 = wd;
        if (wr_ok && (wa == ra2)) rd2 = wd;
        if (ZERO_R0 && (ra1 == '0)) rd1 = '0;
        if (ZERO_R0 && (ra2 == '0)) rd2 = '0;
    end

endmodule

// File: rtl/vector_writeback_regfile.sv
// Writeback-side vector/scalar register file with bypassed read ports and a
// per-register pending scoreboard that stalls decode on RAW/WAW hazards.
module vector_writeback_regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wb_we,
    input  vreg_t     wb_data,
    input  reg_addr_t wb_dest,
    input  logic      wb_vf,
    input  logic      rd_vf1,
    input  logic      rd_vf2,
    input  reg_addr_t ra1,
    input  reg_addr_t ra2,
    input  logic      use1,
    input  logic      use2,
    output vreg_t     rd1,
    output vreg_t     rd2,
    input  logic      iss_valid,
    input  logic      iss_vf,
    input  reg_addr_t iss_dest,
    output logic      stall
);

    vreg_t v_rd1, v_rd2;
    sreg_t s_rd1, s_rd2;

    logic [1:0][NREG-1:0] pending;
    logic [1:0][NREG-1:0] pending_nxt;

    logic clr1, clr2, clr_iss;
    logic raw1, raw2, waw;

    regfile_bank #(.WIDTH(VLEN), .ZERO_R0(1'b0)) u_vbank (
        .clk (clk),
        .rst (rst),
        .we  (wb_we && (bank_e'(wb_vf) == BANK_V)),
        .wa  (wb_dest),
        .wd  (wb_data),
        .ra1 (ra1),
        .ra2 (ra2),
        .rd1 (v_rd1),
        .rd2 (v_rd2)
    );

    regfile_bank #(.WIDTH(SLEN), .ZERO_R0(1'b1)) u_sbank (
        .clk (clk),
        .rst (rst),
        .we  (wb_we && (bank_e'(wb_vf) == BANK_S)),
        .wa  (wb_dest),
        .wd  (wb_data[SLEN-1:0]),
        .ra1 (ra1),
        .ra2 (ra2),
        .rd1 (s_rd1),
        .rd2 (s_rd2)
    );

    assign rd1 = rd_vf1 ? v_rd1 : VLEN'(s_rd1);
    assign rd2 = rd_vf2 ? v_rd2 : VLEN'(s_rd2);

    // A writeback landing this cycle satisfies the hazard it would otherwise raise.
    always_comb begin
        clr1    = wb_we && (wb_vf == rd_vf1) && (wb_dest == ra1);
        clr2    = wb_we && (wb_vf == rd_vf2) && (wb_dest == ra2);
        clr_iss = wb_we && (wb_vf == iss_vf) && (wb_dest == iss_dest);
        raw1    = use1 && pending[rd_vf1][ra1] && !clr1 && !is_s0(rd_vf1, ra1);
        raw2    = use2 && pending[rd_vf2][ra2] && !clr2 && !is_s0(rd_vf2, ra2);
        waw     = iss_valid && pending[iss_vf][iss_dest] && !clr_iss && !is_s0(iss_vf, iss_dest);
        stall   = raw1 || raw2 || waw;
    end

    // Clear on writeback first so a same-cycle issue to the same register wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_we) begin
            pending_nxt[wb_vf][wb_dest] = 1'b0;
        end
        if (iss_valid && !stall && !is_s0(iss_vf, iss_dest)) begin
            pending_nxt[iss_vf][iss_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_vector_writeback_regfile.sv
// Table-driven bench for vector_writeback_regfile with a scoreboard queue of expected outputs.
module tb_vector_writeback_regfile;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      wb_we;
    vreg_t     wb_data;
    reg_addr_t wb_dest;
    logic      wb_vf;
    logic      rd_vf1, rd_vf2;
    reg_addr_t ra1, ra2;
    logic      use1, use2;
    vreg_t     rd1, rd2;
    logic      iss_valid, iss_vf;
    reg_addr_t iss_dest;
    logic      stall;

    vector_writeback_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_data   (wb_data),
        .wb_dest   (wb_dest),
        .wb_vf     (wb_vf),
        .rd_vf1    (rd_vf1),
        .rd_vf2    (rd_vf2),
        .ra1       (ra1),
        .ra2       (ra2),
        .use1      (use1),
        .use2      (use2),
        .rd1       (rd1),
        .rd2       (rd2),
        .iss_valid (iss_valid),
        .iss_vf    (iss_vf),
        .iss_dest  (iss_dest),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic      we;
        logic      vf;
        reg_addr_t dest;
        vreg_t     data;
        logic      v1;
        reg_addr_t a1;
        logic      u1;
        logic      v2;
        reg_addr_t a2;
        logic      u2;
        logic      iv;
        logic      ivf;
        reg_addr_t id;
        vreg_t     e1;
        vreg_t     e2;
        logic      es;
    } step_t;

    typedef struct {
        vreg_t rd1;
        vreg_t rd2;
        logic  stall;
        int    tag;
    } exp_t;

    localparam int NSTEP = 24;

    step_t tbl [NSTEP];
    exp_t  sb [$];
    int    n_applied = 0;
    int    n_miss    = 0;

    localparam vreg_t DV = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam vreg_t DB = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DEADBEEF;
    localparam vreg_t ZB = 128'h00000000_00000000_00000000_DEADBEEF;
    localparam vreg_t D2 = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
    localparam vreg_t DS = 128'hCAFEF00D_CAFEF00D_CAFEF00D_12345678;
    localparam vreg_t ZS = 128'h00000000_00000000_00000000_12345678;
    localparam vreg_t D3 = 128'h33333333_33333333_33333333_33333333;
    localparam vreg_t D4 = 128'h44444444_44444444_44444444_44444444;
    localparam vreg_t D5 = 128'h55555555_55555555_55555555_55555555;

    function automatic step_t mk(logic we, logic vf, int dest, vreg_t data,
                                 logic v1, int a1, logic u1,
                                 logic v2, int a2, logic u2,
                                 logic iv, logic ivf, int id,
                                 vreg_t e1, vreg_t e2, logic es);
        step_t s;
        s.we = we; s.vf = vf; s.dest = AW'(dest); s.data = data;
        s.v1 = v1; s.a1 = AW'(a1); s.u1 = u1;
        s.v2 = v2; s.a2 = AW'(a2); s.u2 = u2;
        s.iv = iv; s.ivf = ivf; s.id = AW'(id);
        s.e1 = e1; s.e2 = e2; s.es = es;
        return s;
    endfunction

    task automatic drive(input step_t s);
        wb_we = s.we; wb_vf = s.vf; wb_dest = s.dest; wb_data = s.data;
        rd_vf1 = s.v1; ra1 = s.a1; use1 = s.u1;
        rd_vf2 = s.v2; ra2 = s.a2; use2 = s.u2;
        iss_valid = s.iv; iss_vf = s.ivf; iss_dest = s.id;
    endtask

    task automatic push_exp(input vreg_t e1, input vreg_t e2, input logic es, input int tag);
        exp_t e;
        e.rd1 = e1; e.rd2 = e2; e.stall = es; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_applied++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e = sb.pop_front();
            if (rd1 !== e.rd1 || rd2 !== e.rd2 || stall !== e.stall) begin
                n_miss++;
                $display("FAIL step%0d: rd1=%h rd2=%h stall=%b, required rd1=%h rd2=%h stall=%b",
                         e.tag, rd1, rd2, stall, e.rd1, e.rd2, e.stall);
            end
        end
    endtask

    task automatic apply(input step_t s, input int tag);
        @(posedge clk);
        #1;
        drive(s);
        push_exp(s.e1, s.e2, s.es, tag);
        #4;
        check_out();
    endtask

    initial begin
        //          we vf dst data  v1 a1 u1  v2 a2 u2  iv ivf id  e1  e2  es
        tbl[0]  = mk(0, 0, 0, '0,   1, 3, 0,  0, 5, 0,  0, 0, 0,  '0, '0, 0);
        tbl[1]  = mk(1, 1, 2, DV,   1, 2, 0,  0, 5, 0,  0, 0, 0,  DV, '0, 0);
        tbl[2]  = mk(0, 0, 0, '0,   1, 2, 0,  0, 2, 0,  0, 0, 0,  DV, '0, 0);
        tbl[3]  = mk(1, 0, 0, DB,   0, 0, 0,  1, 0, 0,  0, 0, 0,  '0, '0, 0);
        tbl[4]  = mk(0, 0, 0, '0,   0, 0, 0,  1, 0, 0,  0, 0, 0,  '0, '0, 0);
        tbl[5]  = mk(1, 0, 7, DB,   0, 0, 0,  0, 7, 0,  0, 0, 0,  '0, ZB, 0);
        tbl[6]  = mk(0, 0, 0, '0,   0, 7, 0,  1, 7, 0,  0, 0, 0,  ZB, '0, 0);
        tbl[7]  = mk(0, 0, 0, '0,   1, 2, 0,  0, 0, 0,  1, 1, 4,  DV, '0, 0);
        tbl[8]  = mk(0, 0, 0, '0,   1, 4, 1,  0, 0, 0,  0, 0, 0,  '0, '0, 1);
        tbl[9]  = mk(1, 1, 4, D2,   1, 4, 1,  0, 0, 0,  0, 0, 0,  D2, '0, 0);
        tbl[10] = mk(0, 0, 0, '0,   1, 4, 1,  0, 0, 0,  0, 0, 0,  D2, '0, 0);
        tbl[11] = mk(0, 0, 0, '0,   1, 2, 0,  0, 0, 0,  1, 0, 6,  DV, '0, 0);
        tbl[12] = mk(0, 0, 0, '0,   1, 2, 0,  0, 6, 1,  1, 0, 6,  DV, '0, 1);
        tbl[13] = mk(1, 0, 6, DS,   1, 2, 0,  0, 6, 1,  0, 0, 0,  DV, ZS, 0);
        tbl[14] = mk(0, 0, 0, '0,   1, 2, 0,  0, 6, 1,  0, 0, 0,  DV, ZS, 0);
        tbl[15] = mk(1, 1, 9, D3,   1, 9, 0,  0, 0, 0,  1, 1, 9,  D3, '0, 0);
        tbl[16] = mk(0, 0, 0, '0,   1, 9, 1,  0, 0, 0,  0, 0, 0,  D3, '0, 1);
        tbl[17] = mk(0, 0, 0, '0,   1, 9, 0,  0, 0, 0,  1, 0, 0,  D3, '0, 0);
        tbl[18] = mk(0, 0, 0, '0,   0, 0, 1,  0, 0, 1,  1, 0, 0,  '0, '0, 0);
        tbl[19] = mk(1, 1, 9, D4,   1, 9, 1,  0, 0, 0,  0, 0, 0,  D4, '0, 0);
        tbl[20] = mk(0, 0, 0, '0,   1, 9, 0,  0, 0, 0,  1, 1, 5,  D4, '0, 0);
        tbl[21] = mk(0, 0, 0, '0,   1, 5, 1,  0, 0, 0,  1, 1, 6,  '0, '0, 1);
        tbl[22] = mk(1, 1, 5, D5,   1, 6, 1,  1, 5, 1,  0, 0, 0,  '0, D5, 0);
        tbl[23] = mk(1, 1, 3, DV,   0, 3, 0,  1, 3, 0,  0, 0, 0,  '0, DV, 0);

        drive(mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, 0));
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;

        for (int i = 0; i < NSTEP; i++) begin
            apply(tbl[i], i);
        end

        // Mid-operation reset: V10 goes pending, then reset drops it and clears the banks.
        apply(mk(0, 0, 0, '0, 1, 2, 0, 0, 0, 0, 1, 1, 10, DV, '0, 0), 100);
        apply(mk(0, 0, 0, '0, 1, 10, 1, 1, 2, 0, 0, 0, 0, '0, DV, 1), 101);
        #1;
        rst = 1'b0;
        #1;
        push_exp('0, '0, 1'b0, 102);
        check_out();
        @(negedge clk);
        #2;
        rst = 1'b1;
        apply(mk(0, 0, 0, '0, 1, 10, 1, 1, 4, 1, 1, 1, 10, '0, '0, 0), 103);
        apply(mk(0, 0, 0, '0, 1, 10, 1, 1, 5, 0, 0, 0, 0, '0, '0, 1), 104);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
